// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Latches two SIZE-bit operands and a
// carry-in on an accepted start, then adds one bit per clock (LSB first)
// through a single full-adder stage and a carry flip-flop. The result is
// presented with a one-cycle done pulse.
//
// Handshake: start is a request strobe that is sampled only in IDLE or DONE.
// The edge that samples start=1 latches a, b and carryIn. busy is high while
// bits are processed. done is high for exactly one cycle, and only then are
// sum/carryOut valid. A start seen while busy is dropped, not queued.
module serial_adder #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            carryIn,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] sum,
  output logic            carryOut,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fa_s, fa_c;

  // Full-adder stage and next-state logic for the shift registers, the carry and the counter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    fa_s    = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so back-to-back runs leave no gap.
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          carry_d = carryIn;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[SIZE-1:1]};
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          // Last bit; counter holds so it never wraps mid-operation.
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carryOut  = carry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at SIZE=8 and
// SIZE=13. Expected results come from plain a+b+cin arithmetic.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8, start13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        cin8, cin13;
  logic        busy8, done8, co8;
  logic        busy13, done13, co13;
  logic [7:0]  sum8;
  logic [12:0] sum13;
  logic [1:0]  st8, st13;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  serial_adder #(.SIZE(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .carryIn(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carryOut(co8), .state_dbg(st8)
  );

  serial_adder #(.SIZE(13)) u13 (
    .clk(clk), .reset(reset), .start(start13), .a(a13), .b(b13), .carryIn(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .carryOut(co13), .state_dbg(st13)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] res(input int w);
    return (w == 8) ? {24'd0, co8, sum8} : {19'd0, co13, sum13};
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy13;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done13;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = s;
    end else begin
      a13 = a[12:0]; b13 = b[12:0]; cin13 = c; start13 = s;
    end
  endtask

  function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic c);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c};
  endfunction

  // One-cycle start pulse, then scramble inputs to show they are not re-sampled.
  task automatic start_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c);
    exp_q.push_back(model(w, a, b, c));
    drive(w, a, b, c, 1'b1);
    tick();
    drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
  endtask

  // Bounded wait for done; counts busy cycles seen before it.
  task automatic wait_done(input int w, input string tag, input int exp_busy);
    int bc;
    int guard;
    logic [32:0] e;
    bc = 0;
    guard = 0;
    while (get_done(w) !== 1'b1 && guard < 60) begin
      if (get_busy(w) === 1'b1) bc++;
      tick();
      guard++;
    end
    chk({tag, "_done"}, {32'd0, get_done(w)}, 33'd1);
    chk({tag, "_busy_cycles"}, 33'(bc), 33'(exp_busy));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    chk({tag, "_result"}, res(w), e);
    chk({tag, "_busy_at_done"}, {32'd0, get_busy(w)}, 33'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint t1, t2;
    int dcnt;
    reset = 1'b1;
    drive(8, 0, 0, 1'b0, 1'b0);
    drive(13, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state for both widths.
    chk("rst8_busy", {32'd0, busy8}, 33'd0);
    chk("rst8_done", {32'd0, done8}, 33'd0);
    chk("rst8_res", res(8), 33'd0);
    chk("rst8_state", {31'd0, st8}, 33'd0);
    chk("rst13_busy", {32'd0, busy13}, 33'd0);
    chk("rst13_done", {32'd0, done13}, 33'd0);
    chk("rst13_res", res(13), 33'd0);

    // Basic add, single done pulse and result hold.
    start_op(8, 32'h0F, 32'h01, 1'b0);
    wait_done(8, "basic", 8);
    chk("basic_res_val", res(8), 33'h010);
    tick();
    chk("basic_done_pulse", {32'd0, done8}, 33'd0);
    chk("basic_idle_busy", {32'd0, busy8}, 33'd0);
    repeat (3) tick();
    chk("basic_hold", res(8), 33'h010);

    // Carry edge cases.
    start_op(8, 32'hFF, 32'h01, 1'b0);
    wait_done(8, "ff_01", 8);
    tick();
    start_op(8, 32'hFF, 32'hFF, 1'b1);
    wait_done(8, "ff_ff_c", 8);
    tick();
    start_op(8, 32'h00, 32'h00, 1'b1);
    wait_done(8, "00_00_c", 8);
    tick();

    // Start during the third busy cycle is dropped.
    start_op(8, 32'h12, 32'h34, 1'b0);
    tick();
    tick();
    drive(8, 32'hAA, 32'h55, 1'b0, 1'b1);
    tick();
    start8 = 1'b0;
    wait_done(8, "ignore", 5);
    tick();
    chk("ignore_no_busy", {32'd0, busy8}, 33'd0);
    dcnt = 0;
    repeat (12) begin
      if (done8 === 1'b1 || busy8 === 1'b1) dcnt++;
      tick();
    end
    chk("ignore_no_second_op", 33'(dcnt), 33'd0);

    // Reset in the fourth busy cycle aborts the operation.
    start_op(8, 32'hF0, 32'h0F, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", {32'd0, busy8}, 33'd0);
    chk("abort_done", {32'd0, done8}, 33'd0);
    chk("abort_res", res(8), 33'd0);
    dcnt = 0;
    repeat (20) begin
      if (done8 === 1'b1) dcnt++;
      tick();
    end
    chk("abort_no_done", 33'(dcnt), 33'd0);
    start_op(8, 32'h01, 32'h01, 1'b0);
    wait_done(8, "after_abort", 8);
    tick();

    // Back-to-back with start held high.
    exp_q.push_back(model(8, 32'h80, 32'h80, 1'b0));
    exp_q.push_back(model(8, 32'h7F, 32'h01, 1'b0));
    drive(8, 32'h80, 32'h80, 1'b0, 1'b1);
    tick();
    drive(8, 32'h7F, 32'h01, 1'b0, 1'b1);
    wait_done(8, "b2b_first", 8);
    t1 = $time;
    tick();
    drive(8, $urandom, $urandom, 1'($urandom), 1'b0);
    chk("b2b_no_gap", {32'd0, busy8}, 33'd1);
    wait_done(8, "b2b_second", 8);
    t2 = $time;
    chk("b2b_spacing", 33'((t2 - t1) / 10), 33'd9);
    tick();

    // Randomized runs at both widths.
    repeat (200) begin
      start_op(8, $urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done(8, "rnd8", 8);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (200) begin
      start_op(13, $urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done(13, "rnd13", 13);
      repeat ($urandom_range(0, 2)) tick();
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder: the additive counterpart of the team's `full_subtract` cell. It latches two `SIZE`-bit operands and a carry-in on a start strobe. It then computes `a + b + carryIn` one bit per clock, LSB first, through a single internal full-adder stage and a carry flip-flop. It presents the sum and carry-out with a one-cycle `done` pulse. It is the area-minimal arithmetic unit for datapaths where `SIZE`-cycle latency is acceptable.

## Interface
- `SIZE`, default 8: operand/sum width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset. Sampled only on the `clk` rising edge.
- `start`  input  1  request strobe; sampled only when the block is not busy.
- `a`  input  `SIZE`  first operand; sampled on the accepting edge only.
- `b`  input  `SIZE`  second operand; sampled on the accepting edge only.
- `carryIn`  input  1  carry into bit 0; sampled on the accepting edge only.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse; `sum`/`carryOut` are valid.
- `sum`  output  `SIZE`  result `(a + b + carryIn) mod 2^SIZE`.
- `carryOut`  output  1  bit `SIZE` of `a + b + carryIn`.

## Operation
- State machine, registered state, three states:
  - `IDLE`
    - `start=1` → `SHIFT`: latch `a` and `b` into shift registers, carry FF ← `carryIn`, bit counter ← 0.
    - Otherwise stay in `IDLE`.
  - `SHIFT`
    - Each edge computes `s = A[0]^B[0]^c` and `c' = A[0]&B[0] | c&(A[0]^B[0])`.
    - Shifts A and B right by 1.
    - Shifts `s` into the MSB of the sum shift register.
    - Carry FF ← `c'`.
    - Counter += 1.
    - When the counter reaches `SIZE-1`, the edge that processes the last bit → `DONE`.
  - `DONE`
    - `done=1`; `sum` register holds the full result; `carryOut` = carry FF.
    - `start=1` → `SHIFT`, with the same latching as from `IDLE` (back-to-back operation).
    - Otherwise → `IDLE`.
- `start` in `SHIFT` is ignored; the operation in flight completes unchanged. `start` is not queued.
- `sum` and `carryOut` hold the last result through `IDLE` until the next accepted start. They change while `SHIFT` runs and are valid only when `done=1`.
- `busy = (state == SHIFT)`; `done = (state == DONE)`. Both are decoded directly from the state register.
- Counter width is `$clog2(SIZE)` bits minimum. The counter does not wrap during an operation.
- Input changes on `a`, `b`, `carryIn` after the accepting edge have no effect on the result.

## Timing
- Reset (`reset=1` at an edge), from any state including mid-`SHIFT`:
  - state → `IDLE`.
  - `busy=0`, `done=0`, `sum=0`, `carryOut=0`.
  - Counter, carry FF and operand registers → 0.
- `reset` has priority over `start` at the same edge.
- Let E0 be the edge where `start` is accepted:
  - `busy` is high for exactly `SIZE` cycles, after E0 through E(SIZE-1).
  - After edge E(SIZE): `done=1` for one cycle, `busy=0`.
  - Latency from the accepting edge to `done` = `SIZE` cycles; throughput is one result per `SIZE+1` cycles.
- `start` held high continuously yields back-to-back operations: a `done` pulse every `SIZE+1` cycles, and no idle cycle between a `done` and the next `busy`.

## Test plan
- Reset then `a=8'h0F`, `b=8'h01`, `carryIn=0`, start for 1 cycle → `busy` high 8 cycles, then `done` for 1 cycle with `sum=8'h10`, `carryOut=0`. `sum` holds `8'h10` afterwards.
- Carry edge cases, each as a separate run:
  - `8'hFF + 8'h01`, `cin=0` → `sum=8'h00`, `carryOut=1`.
  - `8'hFF + 8'hFF`, `cin=1` → `sum=8'hFF`, `carryOut=1`.
  - `8'h00 + 8'h00`, `cin=1` → `sum=8'h01`, `carryOut=0`.
- Start `8'h12 + 8'h34`, then pulse `start` with `a=8'hAA`, `b=8'h55` during cycle 3 of `busy` → single `done` with `sum=8'h46`. No second operation begins.
- Start `8'hF0 + 8'h0F`, assert `reset` during cycle 4 of `busy` → next cycle `busy=0`, `done=0`, `sum=0`, `carryOut=0`. No `done` pulse follows. A new start `8'h01 + 8'h01` then gives `sum=8'h02`.
- `start` held high with operand pairs `(8'h80, 8'h80, 0)` then `(8'h7F, 8'h01, 0)` changed right after each accepting edge → `done` pulses 9 cycles apart with `{carryOut,sum}=9'h100`, then `9'h080`. No gap cycle between operations.
- Randomized self-check: 200 random operand and `carryIn` sets at `SIZE=8` and `SIZE=13`, comparing `{carryOut,sum}` against `a+b+carryIn` at each `done`.
